// File: rtl/cb_spi_reg_bridge.sv
`timescale 1ns/1ps
// SPI mode-0 responder: decodes 32-bit read/write command frames into single
// register-bus transactions and shifts read data back out on MISO.
module cb_spi_reg_bridge #(
    parameter int unsigned ADDR_BITS = 22,
    parameter logic [31:0] BAD_DATA  = 32'hDEADDEAD,
    parameter int unsigned TURN_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 sclk_i,
    input  logic                 mosi_i,
    input  logic                 cs_b_i,
    output logic                 miso_o,
    output logic                 en_o,
    output logic                 wr_o,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic [31:0]          dat_o,
    input  logic [31:0]          dat_i,
    input  logic                 ack_i,
    output logic                 frame_err_o,
    output logic                 rd_timeout_o,
    output logic [2:0]           dbg_state_o
);

    // Bus handshake: en_o with wr_o/addr_o/dat_o is held until ack_i is seen on a
    // clk edge, en_o drops on that edge; ack_i while en_o is low is ignored.

    localparam int unsigned CW = $clog2(64 + TURN_BITS + 1);
    localparam logic [CW-1:0] CNT_CMD_LAST  = CW'(31);
    localparam logic [CW-1:0] CNT_WR_LAST   = CW'(63);
    localparam logic [CW-1:0] CNT_TURN_DONE = CW'(32 + TURN_BITS);
    localparam logic [CW-1:0] CNT_RD_LAST   = CW'(63 + TURN_BITS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_BUS  = 3'd3,
        ST_RD_TURN = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_DRAIN   = 3'd6
    } state_t;

    state_t state, state_d;

    logic [2:0] sclk_sr;
    logic [2:0] cs_sr;
    logic [1:0] mosi_sr;
    logic sclk_rise, sclk_fall, cs_fall, cs_high, mosi_s;
    logic in_frame, start, frame_abort, own_ack, need_issue;
    logic [CW-1:0] cnt;
    logic [31:0] rx_sr, rx_next, rd_buf, tx_sr, tx_load;
    logic [ADDR_BITS-1:0] addr_q;
    logic issued, cur_owner, rd_acked;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sclk_sr <= '0;
            cs_sr   <= '0;
            mosi_sr <= '0;
        end else begin
            sclk_sr <= {sclk_sr[1:0], sclk_i};
            cs_sr   <= {cs_sr[1:0], cs_b_i};
            mosi_sr <= {mosi_sr[0], mosi_i};
        end
    end

    assign sclk_rise   = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall   = ~sclk_sr[1] & sclk_sr[2];
    assign cs_fall     = ~cs_sr[1] & cs_sr[2];
    assign cs_high     = cs_sr[1];
    assign mosi_s      = mosi_sr[1];
    assign rx_next     = {rx_sr[30:0], mosi_s};
    assign in_frame    = (state == ST_CMD) || (state == ST_WR_DATA) ||
                         (state == ST_RD_TURN) || (state == ST_RD_DATA);
    assign start       = ((state == ST_IDLE) || (state == ST_DRAIN)) && cs_fall;
    assign frame_abort = in_frame && cs_high;
    assign own_ack     = en_o && ack_i && cur_owner;
    // A bus cycle left over from an aborted frame must finish before this frame issues.
    assign need_issue  = !en_o && !issued && ((state == ST_RD_TURN) || (state == ST_WR_BUS));
    assign tx_load     = rd_acked ? rd_buf : BAD_DATA;
    assign dbg_state_o = state;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (cs_fall) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (cs_high) state_d = ST_IDLE;
                else if (sclk_rise && cnt == CNT_CMD_LAST)
                    state_d = rx_sr[30] ? ST_WR_DATA : ST_RD_TURN;
            end
            ST_WR_DATA: begin
                if (cs_high) state_d = ST_IDLE;
                else if (sclk_rise && cnt == CNT_WR_LAST) state_d = ST_WR_BUS;
            end
            ST_WR_BUS: begin
                if (own_ack) state_d = ST_DRAIN;
            end
            ST_RD_TURN: begin
                if (cs_high) state_d = ST_IDLE;
                else if (sclk_fall && cnt == CNT_TURN_DONE) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (cs_high) state_d = ST_IDLE;
                else if (sclk_rise && cnt == CNT_RD_LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cs_fall) state_d = ST_CMD;
                else if (cs_high) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Receive side: bit counter, MOSI shift register and captured address.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt    <= '0;
            rx_sr  <= '0;
            addr_q <= '0;
        end else if (start) begin
            cnt   <= '0;
            rx_sr <= '0;
        end else if (sclk_rise && in_frame && !frame_abort) begin
            cnt <= cnt + CW'(1);
            if ((state == ST_CMD) || (state == ST_WR_DATA)) rx_sr <= rx_next;
            if ((state == ST_CMD) && (cnt == CNT_CMD_LAST)) addr_q <= rx_next[ADDR_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            en_o      <= 1'b0;
            wr_o      <= 1'b0;
            addr_o    <= '0;
            dat_o     <= '0;
            rd_buf    <= '0;
            rd_acked  <= 1'b0;
            issued    <= 1'b0;
            cur_owner <= 1'b0;
        end else begin
            if (en_o && ack_i) begin
                en_o      <= 1'b0;
                wr_o      <= 1'b0;
                cur_owner <= 1'b0;
                if (cur_owner && (state == ST_RD_TURN)) begin
                    rd_buf   <= dat_i;
                    rd_acked <= 1'b1;
                end
            end else if (need_issue) begin
                en_o      <= 1'b1;
                wr_o      <= (state == ST_WR_BUS);
                addr_o    <= addr_q;
                dat_o     <= (state == ST_WR_BUS) ? rx_sr : 32'h0;
                issued    <= 1'b1;
                cur_owner <= 1'b1;
            end
            // An orphaned cycle keeps en_o until its ack, but its result is never used.
            if (frame_abort) cur_owner <= 1'b0;
            if (start) begin
                issued    <= 1'b0;
                rd_acked  <= 1'b0;
                cur_owner <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tx_sr        <= '0;
            miso_o       <= 1'b0;
            frame_err_o  <= 1'b0;
            rd_timeout_o <= 1'b0;
        end else begin
            frame_err_o  <= frame_abort;
            rd_timeout_o <= 1'b0;
            if ((state == ST_RD_TURN) && (state_d == ST_RD_DATA)) begin
                tx_sr        <= tx_load;
                miso_o       <= tx_load[31];
                rd_timeout_o <= !rd_acked;
            end else if ((state == ST_RD_DATA) && (state_d == ST_RD_DATA)) begin
                if (sclk_fall) begin
                    tx_sr  <= {tx_sr[30:0], 1'b0};
                    miso_o <= tx_sr[30];
                end
            end else begin
                miso_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cb_spi_reg_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for cb_spi_reg_bridge: SPI master driver, bus responder,
// frame-level reference model with a per-cycle compare process.
module tb_cb_spi_reg_bridge;

  localparam int AW = 22;
  localparam int TURN = 8;
  localparam int TW = 1 + AW + 32;
  localparam logic [31:0] BAD = 32'hDEADDEAD;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic sclk_i = 1'b0;
  logic mosi_i = 1'b0;
  logic cs_b_i = 1'b1;
  logic miso_o, en_o, wr_o, ack_i, frame_err_o, rd_timeout_o;
  logic [AW-1:0] addr_o;
  logic [31:0] dat_o, dat_i;
  logic [2:0] dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  cb_spi_reg_bridge dut (
    .clk(clk), .rst_b(rst_b), .sclk_i(sclk_i), .mosi_i(mosi_i), .cs_b_i(cs_b_i),
    .miso_o(miso_o), .en_o(en_o), .wr_o(wr_o), .addr_o(addr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .frame_err_o(frame_err_o),
    .rd_timeout_o(rd_timeout_o), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [TW-1:0] exp_q[$];
  int exp_ferr = 0, exp_tmo = 0;
  int ferr_seen = 0, tmo_seen = 0, bus_cycles = 0;
  logic last_wr;
  logic [AW-1:0] last_addr;
  logic [31:0] last_dat, last_rd_word;

  int ack_lat = 3;
  bit ack_hold = 1'b0;
  logic [31:0] rd_word = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus responder ----------------
  initial begin : responder
    int en_cnt;
    en_cnt = 0;
    ack_i = 1'b0;
    dat_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (en_o === 1'b1 && ack_i == 1'b0) begin
        en_cnt++;
        if (!ack_hold && en_cnt >= ack_lat) begin
          ack_i = 1'b1;
          dat_i = rd_word;
        end else begin
          dat_i = $urandom;
        end
      end else begin
        ack_i = 1'b0;
        en_cnt = 0;
        dat_i = $urandom;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_en = 1'b0, prev_ack = 1'b0;
  logic [TW-1:0] held;
  int cs_hi = 0;

  always @(negedge clk) begin
    logic [TW-1:0] e;
    if (!rst_b) begin
      prev_en = 1'b0;
      prev_ack = 1'b0;
      cs_hi = 0;
    end else begin
      if (prev_en && prev_ack) check("en_drop_after_ack", 64'(en_o), 64'(0));
      if (en_o && !prev_en) begin
        bus_cycles++;
        held = {wr_o, addr_o, dat_o};
        last_wr = wr_o;
        last_addr = addr_o;
        last_dat = dat_o;
        check("bus_cycle_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("bus_wr", 64'(wr_o), 64'(e[TW-1]));
          check("bus_addr", 64'(addr_o), 64'(e[AW+31:32]));
          if (e[TW-1]) check("bus_dat", 64'(dat_o), 64'(e[31:0]));
        end
      end else if (en_o && prev_en) begin
        check("bus_hold", 64'({wr_o, addr_o, dat_o}), 64'(held));
      end
      if (frame_err_o) ferr_seen++;
      if (rd_timeout_o) tmo_seen++;
      if (cs_b_i) cs_hi++;
      else cs_hi = 0;
      if (cs_hi >= 5) check("miso_idle", 64'(miso_o), 64'(0));
      prev_en = en_o;
      prev_ack = ack_i;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_bus_idle();
    for (int n = 0; n < 400 && en_o !== 1'b0; n++) @(posedge clk);
    check("bus_idle_timeout", 64'(en_o), 64'(0));
    repeat (3) @(posedge clk);
  endtask

  // One SPI frame as master; abort_at > 0 raises CS_B after that many rising edges.
  // The model expectations for the frame are queued before any pin moves.
  task automatic run_frame(input logic [31:0] cmd, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int abort_at, input int lat,
                           input bit hold, input bit wait_idle);
    bit is_wr;
    int total, nb, extra, stray, half;
    logic [31:0] got, want;
    is_wr = cmd[31];
    total = is_wr ? 64 : 64 + TURN;
    nb = (abort_at > 0) ? abort_at : total;
    extra = (abort_at > 0) ? 0 : $urandom_range(0, 4);
    stray = 0;
    got = 32'h0;
    want = hold ? BAD : rdata;
    ack_lat = lat;
    ack_hold = hold;
    rd_word = rdata;
    if (abort_at == 0 || (!is_wr && abort_at > 32))
      exp_q.push_back({is_wr, cmd[AW-1:0], is_wr ? wdata : 32'h0});
    if (abort_at > 0) exp_ferr++;
    if (!is_wr && abort_at == 0 && hold) exp_tmo++;

    cs_b_i = 1'b0;
    #($urandom_range(40, 55));
    for (int i = 1; i <= nb + extra; i++) begin
      if (i <= 32) mosi_i = cmd[32-i];
      else if (is_wr && i <= 64) mosi_i = wdata[64-i];
      else mosi_i = 1'($urandom);
      half = $urandom_range(40, 55);
      #(half);
      if (!is_wr && abort_at == 0 && i > 32 + TURN && i <= 64 + TURN) got = {got[30:0], miso_o};
      else if (miso_o !== 1'b0) stray++;
      sclk_i = 1'b1;
      half = $urandom_range(40, 55);
      #(half);
      sclk_i = 1'b0;
    end
    #($urandom_range(40, 55));
    cs_b_i = 1'b1;
    if (!is_wr && abort_at == 0) begin
      last_rd_word = got;
      check("rd_word", 64'(got), 64'(want));
    end
    check("miso_stray", 64'(stray), 64'(0));
    repeat (6) @(posedge clk);
    if (wait_idle) wait_bus_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int b0, f0, t0;
    logic [31:0] r;
    bit w;
    int abort;
    #2 rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", 64'(en_o), 64'(0));
    check("rst_wr", 64'(wr_o), 64'(0));
    check("rst_miso", 64'(miso_o), 64'(0));
    check("rst_addr", 64'(addr_o), 64'(0));
    check("rst_dat", 64'(dat_o), 64'(0));
    check("rst_pulses", 64'({frame_err_o, rd_timeout_o}), 64'(0));
    check("rst_state_idle", 64'(dbg_state), 64'(0));
    rst_b = 1'b1;
    repeat (5) @(posedge clk);

    // Directed write
    b0 = bus_cycles;
    run_frame(32'h80030404, 32'h00000001, 32'h0, 0, 3, 1'b0, 1'b1);
    check("wr_one_cycle", 64'(bus_cycles - b0), 64'(1));
    check("wr_lit_addr", 64'(last_addr), 64'(22'h030404));
    check("wr_lit_wr", 64'(last_wr), 64'(1));
    check("wr_lit_dat", 64'(last_dat), 64'(32'h00000001));
    check("wr_no_frame_err", 64'(ferr_seen), 64'(0));

    // Directed on-time read
    run_frame(32'h00030404, 32'h0, 32'h12345678, 0, 5, 1'b0, 1'b1);
    check("rd_lit_word", 64'(last_rd_word), 64'(32'h12345678));
    check("rd_lit_addr", 64'(last_addr), 64'(22'h030404));
    check("rd_lit_wr", 64'(last_wr), 64'(0));
    check("rd_no_timeout", 64'(tmo_seen), 64'(0));

    // Read timeout, late ack, then a good read
    run_frame(32'h00010008, 32'h0, 32'h0BADF00D, 0, 3, 1'b1, 1'b0);
    check("tmo_lit_word", 64'(last_rd_word), 64'(32'hDEADDEAD));
    check("tmo_one_pulse", 64'(tmo_seen), 64'(1));
    check("tmo_en_still_high", 64'(en_o), 64'(1));
    ack_hold = 1'b0;
    wait_bus_idle();
    run_frame(32'h00010008, 32'h0, 32'hCAFEF00D, 0, 2, 1'b0, 1'b1);
    check("after_tmo_lit_word", 64'(last_rd_word), 64'(32'hCAFEF00D));

    // Abort after 20 command bits, then a normal write
    b0 = bus_cycles;
    f0 = ferr_seen;
    run_frame(32'h80012345, 32'h55AA55AA, 32'h0, 20, 3, 1'b0, 1'b0);
    check("abort_one_frame_err", 64'(ferr_seen - f0), 64'(1));
    check("abort_no_bus", 64'(bus_cycles - b0), 64'(0));
    run_frame(32'h80012345, 32'h55AA55AA, 32'h0, 0, 4, 1'b0, 1'b1);
    check("post_abort_lit_dat", 64'(last_dat), 64'(32'h55AA55AA));

    // Asynchronous reset while the write sits in WR_BUS
    run_frame(32'h80000100, 32'hA5A5A5A5, 32'h0, 0, 3, 1'b1, 1'b0);
    check("wrbus_en_high", 64'(en_o), 64'(1));
    @(posedge clk);
    #3 rst_b = 1'b0;
    #1;
    check("async_rst_en", 64'(en_o), 64'(0));
    check("async_rst_wr", 64'(wr_o), 64'(0));
    check("async_rst_miso", 64'(miso_o), 64'(0));
    check("async_rst_pulses", 64'({frame_err_o, rd_timeout_o}), 64'(0));
    ack_hold = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_b = 1'b1;
    repeat (5) @(posedge clk);
    run_frame(32'h80000104, 32'h0F1E2D3C, 32'h0, 0, 2, 1'b0, 1'b1);
    check("post_rst_lit_dat", 64'(last_dat), 64'(32'h0F1E2D3C));

    // Randomized frames, including aborts and orphaned read cycles
    t0 = tmo_seen;
    for (int k = 0; k < 24; k++) begin
      w = 1'($urandom_range(0, 1));
      r = $urandom;
      abort = 0;
      if ($urandom_range(0, 4) == 4) begin
        if (w) abort = $urandom_range(1, 63);
        else abort = $urandom_range(0, 1) ? $urandom_range(1, 31) : $urandom_range(33, 39);
      end
      run_frame({w, r[30:0]}, $urandom, $urandom, abort, $urandom_range(1, 20), 1'b0, abort == 0);
    end
    wait_bus_idle();
    check("rand_no_timeout", 64'(tmo_seen - t0), 64'(0));

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("frame_err_total", 64'(ferr_seen), 64'(exp_ferr));
    check("rd_timeout_total", 64'(tmo_seen), 64'(exp_tmo));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
